// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback request, claim, query and register-file write bundle
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [5*NUM_REQ-1:0]  req_reg;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  claim_valid;
  logic [4:0]            claim_reg;
  logic                  claim_stall;
  logic [4:0]            query_reg1;
  logic [4:0]            query_reg2;
  logic                  busy1;
  logic                  busy2;
  logic                  write_control;
  logic [4:0]            write_reg;
  logic [31:0]           write_data;
  logic [31:0]           pending_regs;

  modport master (
    output req_valid, req_reg, req_data, claim_valid, claim_reg, query_reg1, query_reg2,
    input  req_ready, claim_stall, busy1, busy2, write_control, write_reg, write_data,
           pending_regs
  );

  modport slave (
    input  req_valid, req_reg, req_data, claim_valid, claim_reg, query_reg1, query_reg2,
    output req_ready, claim_stall, busy1, busy2, write_control, write_reg, write_data,
           pending_regs
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter with pending-write scoreboard
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3
) (
  input logic                 r_clk,
  input logic                 reset,
  input logic                 r_clk_enable,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [31:0]      pending_q, pending_d;
  logic             write_control_q, write_control_d;
  logic [4:0]       write_reg_q, write_reg_d;
  logic [31:0]      write_data_q, write_data_d;

  logic [PTR_W-1:0]   hi_idx, lo_idx, grant_idx;
  logic               hi_found, grant_found;
  logic [NUM_REQ-1:0] ready;
  logic [4:0]         sel_reg;
  logic [31:0]        sel_data;
  logic               xfer;
  logic               claim_hit;
  logic               claim_accept;

  // Round-robin pick: lowest valid index at or above ptr, otherwise wrap to lowest valid.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        lo_idx = PTR_W'(i);
        if (i >= int'(ptr_q)) begin
          hi_idx   = PTR_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    grant_found = |bus.req_valid;
    grant_idx   = hi_found ? hi_idx : lo_idx;
  end

  // One-hot grant (suppressed while stalled) and mux of the granted requester's slices.
  always_comb begin
    ready    = '0;
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_clk_enable && grant_found && (grant_idx == PTR_W'(i))) begin
        ready[i] = 1'b1;
        sel_reg  = bus.req_reg[5*i +: 5];
        sel_data = bus.req_data[32*i +: 32];
      end
    end
  end

  assign xfer         = |(ready & bus.req_valid);
  assign claim_hit    = bus.claim_valid && (bus.claim_reg != 5'd0);
  assign claim_accept = claim_hit && !pending_q[bus.claim_reg];

  // Next state: pointer advance, output stage load, scoreboard clear-then-set so set wins.
  always_comb begin
    ptr_d           = ptr_q;
    pending_d       = pending_q;
    write_control_d = write_control_q;
    write_reg_d     = write_reg_q;
    write_data_d    = write_data_q;
    if (r_clk_enable) begin
      write_control_d = 1'b0;
      if (xfer) begin
        ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
        if (sel_reg != 5'd0) begin
          write_control_d    = 1'b1;
          write_reg_d        = sel_reg;
          write_data_d       = sel_data;
          pending_d[sel_reg] = 1'b0;
        end
      end
      if (claim_accept) begin
        pending_d[bus.claim_reg] = 1'b1;
      end
    end
    pending_d[0] = 1'b0;
  end

  // State registers; reset discards in-flight writebacks and claims.
  always_ff @(posedge r_clk or posedge reset) begin
    if (reset) begin
      ptr_q           <= '0;
      pending_q       <= '0;
      write_control_q <= 1'b0;
      write_reg_q     <= '0;
      write_data_q    <= '0;
    end else begin
      ptr_q           <= ptr_d;
      pending_q       <= pending_d;
      write_control_q <= write_control_d;
      write_reg_q     <= write_reg_d;
      write_data_q    <= write_data_d;
    end
  end

  assign bus.req_ready     = ready;
  assign bus.claim_stall   = claim_hit && pending_q[bus.claim_reg];
  // A register just handed to the write port is still stale until the file commits it.
  assign bus.busy1         = (bus.query_reg1 != 5'd0) &&
                             (pending_q[bus.query_reg1] ||
                              (write_control_q && (write_reg_q == bus.query_reg1)));
  assign bus.busy2         = (bus.query_reg2 != 5'd0) &&
                             (pending_q[bus.query_reg2] ||
                              (write_control_q && (write_reg_q == bus.query_reg2)));
  assign bus.write_control = write_control_q;
  assign bus.write_reg     = write_reg_q;
  assign bus.write_data    = write_data_q;
  assign bus.pending_regs  = pending_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - vector table, reset/stall sequences and random run against a model
module tb_regfile_wb_arbiter;
  localparam int N = 3;
  localparam logic [31:0] D0 = 32'h1111_0000;
  localparam logic [31:0] D1 = 32'hDEAD_BEEF;
  localparam logic [31:0] D2 = 32'h2222_0000;

  logic r_clk = 1'b0;
  logic reset;
  logic r_clk_enable;

  regfile_wb_arbiter_if #(.NUM_REQ(N)) bus ();

  regfile_wb_arbiter #(.NUM_REQ(N)) dut (
    .r_clk        (r_clk),
    .reset        (reset),
    .r_clk_enable (r_clk_enable),
    .bus          (bus)
  );

  always #5 r_clk = ~r_clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [N-1:0] tv_valid;
  logic [4:0]   tv_reg [N];
  logic [31:0]  tv_data [N];
  logic         tv_cv;
  logic [4:0]   tv_cr, tv_q1, tv_q2;

  int          m_ptr;
  bit          m_pend [32];
  bit          m_wc;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;
  int          m_last;

  typedef struct {
    logic [31:0] en, v, r0, r1, r2, cv, cr, q1, q2;
    logic [31:0] e_ready, e_stall, e_b1, e_b2, e_wc, e_wr, e_wd, e_pend;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]         = tv_valid[i];
      bus.req_reg[5*i +: 5]    = tv_reg[i];
      bus.req_data[32*i +: 32] = tv_data[i];
    end
    bus.claim_valid = tv_cv;
    bus.claim_reg   = tv_cr;
    bus.query_reg1  = tv_q1;
    bus.query_reg2  = tv_q2;
  endtask

  task automatic m_reset();
    m_ptr = 0;
    m_wc  = 0;
    m_wr  = '0;
    m_wd  = '0;
    m_last = -1;
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
  endtask

  function automatic int m_grant();
    if (!r_clk_enable) return -1;
    for (int k = 0; k < N; k++)
      if (tv_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic bit m_busy(input logic [4:0] q);
    return (q != 0) && (m_pend[q] || (m_wc && m_wr == q));
  endfunction

  task automatic m_check(input int cyc);
    int g;
    logic [31:0] pk;
    logic [31:0] er;
    g  = m_grant();
    er = (g >= 0) ? (32'd1 << g) : 32'd0;
    for (int i = 0; i < 32; i++) pk[i] = m_pend[i];
    chk($sformatf("rnd%0d req_ready", cyc), 32'(bus.req_ready), er);
    chk($sformatf("rnd%0d claim_stall", cyc), 32'(bus.claim_stall),
        32'(tv_cv && tv_cr != 0 && m_pend[tv_cr]));
    chk($sformatf("rnd%0d busy1", cyc), 32'(bus.busy1), 32'(m_busy(tv_q1)));
    chk($sformatf("rnd%0d busy2", cyc), 32'(bus.busy2), 32'(m_busy(tv_q2)));
    chk($sformatf("rnd%0d write_control", cyc), 32'(bus.write_control), 32'(m_wc));
    chk($sformatf("rnd%0d write_reg", cyc), 32'(bus.write_reg), 32'(m_wr));
    chk($sformatf("rnd%0d write_data", cyc), bus.write_data, m_wd);
    chk($sformatf("rnd%0d pending_regs", cyc), bus.pending_regs, pk);
  endtask

  task automatic m_edge();
    int g;
    bit acc;
    g = m_grant();
    m_last = g;
    if (!r_clk_enable) return;
    acc  = tv_cv && tv_cr != 0 && !m_pend[tv_cr];
    m_wc = 0;
    if (g >= 0) begin
      m_ptr = (g + 1) % N;
      if (tv_reg[g] != 0) begin
        m_wc = 1;
        m_wr = tv_reg[g];
        m_wd = tv_data[g];
        m_pend[tv_reg[g]] = 0;
      end
    end
    if (acc) m_pend[tv_cr] = 1;
  endtask

  initial begin
    // en, v, r0, r1, r2, cv, cr, q1, q2 | ready, stall, b1, b2, wc, wr, wd, pend
    tbl.push_back(vec_t'{1, 0,  0,  0,  0, 1, 5,  5, 0, 0, 0, 0, 0, 0,  0, 0,  0});
    tbl.push_back(vec_t'{1, 2,  0,  5,  0, 0, 0,  5, 0, 2, 0, 1, 0, 0,  0, 0,  32'h20});
    tbl.push_back(vec_t'{1, 0,  0,  5,  0, 0, 0,  5, 0, 0, 0, 1, 0, 1,  5, D1, 0});
    tbl.push_back(vec_t'{1, 0,  0,  0,  0, 0, 0,  5, 0, 0, 0, 0, 0, 0,  5, D1, 0});
    tbl.push_back(vec_t'{1, 4,  0,  0,  0, 0, 0,  0, 0, 4, 0, 0, 0, 0,  5, D1, 0});
    tbl.push_back(vec_t'{1, 0,  0,  0,  0, 1, 0,  0, 0, 0, 0, 0, 0, 0,  5, D1, 0});
    tbl.push_back(vec_t'{1, 7, 10, 11, 12, 0, 0, 10, 0, 1, 0, 0, 0, 0,  5, D1, 0});
    tbl.push_back(vec_t'{1, 7, 10, 11, 12, 0, 0, 10, 0, 2, 0, 1, 0, 1, 10, D0, 0});
    tbl.push_back(vec_t'{1, 7, 10, 11, 12, 0, 0, 10, 0, 4, 0, 0, 0, 1, 11, D1, 0});
    tbl.push_back(vec_t'{1, 7, 10, 11, 12, 0, 0, 10, 0, 1, 0, 0, 0, 1, 12, D2, 0});
    tbl.push_back(vec_t'{1, 7, 10, 11, 12, 0, 0, 10, 0, 2, 0, 1, 0, 1, 10, D0, 0});
    tbl.push_back(vec_t'{1, 7, 10, 11, 12, 0, 0, 10, 0, 4, 0, 0, 0, 1, 11, D1, 0});
    tbl.push_back(vec_t'{1, 0,  0,  0,  0, 1, 7,  0, 0, 0, 0, 0, 0, 1, 12, D2, 0});
    tbl.push_back(vec_t'{1, 0,  0,  0,  0, 1, 7,  7, 0, 0, 1, 1, 0, 0, 12, D2, 32'h80});
    tbl.push_back(vec_t'{1, 1,  7,  0,  0, 1, 8,  7, 8, 1, 0, 1, 0, 0, 12, D2, 32'h80});
    tbl.push_back(vec_t'{1, 2,  0,  8,  0, 1, 8,  7, 8, 2, 1, 1, 1, 1,  7, D0, 32'h100});
    tbl.push_back(vec_t'{1, 4,  0,  0,  8, 1, 8,  0, 8, 4, 0, 0, 1, 1,  8, D1, 0});
    tbl.push_back(vec_t'{0, 7, 10, 11, 12, 1, 9,  0, 8, 0, 0, 0, 1, 1,  8, D2, 32'h100});
    tbl.push_back(vec_t'{0, 7, 10, 11, 12, 1, 9,  0, 8, 0, 0, 0, 1, 1,  8, D2, 32'h100});
    tbl.push_back(vec_t'{0, 7, 10, 11, 12, 1, 9,  0, 8, 0, 0, 0, 1, 1,  8, D2, 32'h100});
    tbl.push_back(vec_t'{1, 7, 10, 11, 12, 0, 0,  0, 8, 1, 0, 0, 1, 1,  8, D2, 32'h100});
    tbl.push_back(vec_t'{1, 0,  0,  0,  0, 1, 8, 10, 0, 0, 1, 1, 0, 1, 10, D0, 32'h100});

    // Reset held with every requester valid: grant must start at requester 0.
    reset        = 1'b1;
    r_clk_enable = 1'b1;
    tv_valid = '1;
    for (int i = 0; i < N; i++) begin
      tv_reg[i]  = 5'(10 + i);
      tv_data[i] = 32'h0;
    end
    tv_cv = 1'b0; tv_cr = '0; tv_q1 = '0; tv_q2 = '0;
    drive();
    #2;
    chk("reset req_ready", 32'(bus.req_ready), 32'h1);
    chk("reset pending_regs", bus.pending_regs, 32'h0);
    chk("reset write_control", 32'(bus.write_control), 32'h0);
    @(posedge r_clk); #1;
    reset = 1'b0;
    tv_valid = '0;

    // Directed vector table, one enabled or stalled edge per row.
    foreach (tbl[r]) begin
      r_clk_enable = tbl[r].en[0];
      for (int i = 0; i < N; i++) tv_valid[i] = tbl[r].v[i];
      tv_reg[0] = tbl[r].r0[4:0];
      tv_reg[1] = tbl[r].r1[4:0];
      tv_reg[2] = tbl[r].r2[4:0];
      tv_data[0] = D0; tv_data[1] = D1; tv_data[2] = D2;
      tv_cv = tbl[r].cv[0];
      tv_cr = tbl[r].cr[4:0];
      tv_q1 = tbl[r].q1[4:0];
      tv_q2 = tbl[r].q2[4:0];
      drive();
      #2;
      chk($sformatf("row%0d req_ready", r), 32'(bus.req_ready), tbl[r].e_ready);
      chk($sformatf("row%0d claim_stall", r), 32'(bus.claim_stall), tbl[r].e_stall);
      chk($sformatf("row%0d busy1", r), 32'(bus.busy1), tbl[r].e_b1);
      chk($sformatf("row%0d busy2", r), 32'(bus.busy2), tbl[r].e_b2);
      chk($sformatf("row%0d write_control", r), 32'(bus.write_control), tbl[r].e_wc);
      chk($sformatf("row%0d write_reg", r), 32'(bus.write_reg), tbl[r].e_wr);
      chk($sformatf("row%0d write_data", r), bus.write_data, tbl[r].e_wd);
      chk($sformatf("row%0d pending_regs", r), bus.pending_regs, tbl[r].e_pend);
      @(posedge r_clk); #1;
    end

    // Mid-cycle reset: ptr is 1 here, so grant must jump back to requester 0 before any edge.
    r_clk_enable = 1'b1;
    tv_valid = '1;
    tv_cv = 1'b0;
    drive();
    #2;
    chk("pre-reset req_ready", 32'(bus.req_ready), 32'h2);
    reset = 1'b1;
    #1;
    chk("midreset req_ready", 32'(bus.req_ready), 32'h1);
    chk("midreset write_control", 32'(bus.write_control), 32'h0);
    chk("midreset write_reg", 32'(bus.write_reg), 32'h0);
    chk("midreset write_data", bus.write_data, 32'h0);
    chk("midreset pending_regs", bus.pending_regs, 32'h0);
    @(posedge r_clk); #1;
    reset = 1'b0;
    tv_valid = '0;
    m_reset();

    // Random traffic; a requester keeps its reg/data until the model says it was granted.
    for (int c = 0; c < 800; c++) begin
      r_clk_enable = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < N; i++) begin
        if (!(tv_valid[i] && m_last != i)) begin
          tv_valid[i] = ($urandom_range(0, 2) != 0);
          tv_reg[i]   = 5'($urandom_range(0, 9));
          tv_data[i]  = $urandom;
        end
      end
      tv_cv = ($urandom_range(0, 1) != 0);
      tv_cr = 5'($urandom_range(0, 9));
      tv_q1 = 5'($urandom_range(0, 9));
      tv_q2 = 5'($urandom_range(0, 9));
      drive();
      #2;
      m_check(c);
      m_edge();
      @(posedge r_clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
